// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: operation encodings and FSM state encodings.
package muldiv_unit_pkg;

  // Bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem          partial remainder, always < divisor when divisor != 0
//   dividend_bit next dividend bit shifted into the remainder
//   divisor      divisor magnitude
//   rem_next     updated partial remainder
//   q_bit        quotient bit produced by this step
module muldiv_unit_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // With rem < divisor, shifted < 2*divisor, so a non-negative difference always
  // fits in WIDTH bits and a negative one always sets the top bit.
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start, op       launch request (sampled in idle) and operation select
//   a, b            rs / rt operands
//   hi_we, lo_we    MTHI / MTLO write enables, wdata is the write data
//   busy            operation in flight
//   done            one-cycle pulse, HI/LO hold the new result
//   div_by_zero     pulses with done when a divide had b == 0
//   hi, lo          architectural HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q, rem_neg_q, dz_q;
  logic               done_q, dz_pulse_q;

  // Operand magnitudes and result signs, computed from the live inputs at launch.
  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  logic op_is_div;
  assign op_is_div = (op_q == OpDiv) || (op_q == OpDivu);

  // Multiply step: add multiplicand into the upper half when the low bit is set,
  // then shift the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_b_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: remainder in the upper half, dividend shifts out of the top of the
  // lower half while quotient bits shift in at the bottom.
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  muldiv_unit_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem         (acc_q[2*WIDTH-1:WIDTH]),
    .dividend_bit(acc_q[WIDTH-1]),
    .divisor     (mag_b_q),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  assign div_next = {rem_next, acc_q[WIDTH-2:0], q_bit};

  // Sign fix-up applied on the way into HI/LO.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      // One extra RUN cycle after the last iteration gives the 34-cycle latency.
      StRun:   if (cnt_q == CntDone) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= OpMult;
      acc_q      <= '0;
      mag_b_q    <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= op_e'(op);
            acc_q     <= {{WIDTH{1'b0}}, mag_a};
            mag_b_q   <= mag_b;
            cnt_q     <= '0;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= is_div & (b == '0);
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        StRun: begin
          if (cnt_q != CntDone) begin
            acc_q <= op_is_div ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          done_q     <= 1'b1;
          dz_pulse_q <= dz_q;
          if (!dz_q) begin
            if (op_is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dz_pulse_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: each launch pushes the reference result,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference for HI/LO after one operation.
  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, y,
                                     input logic [31:0] hi0, lo0);
    exp_t        res;
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    res.dz = 1'b0;
    res.hi = hi0;
    res.lo = lo0;
    case (o)
      2'd0: begin p = sx * sy; res.hi = p[63:32]; res.lo = p[31:0]; end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; res.hi = up[63:32]; res.lo = up[31:0]; end
      2'd2: begin
        if (y == 0) res.dz = 1'b1;
        else begin q = sx / sy; r = sx % sy; res.lo = q[31:0]; res.hi = r[31:0]; end
      end
      default: begin
        if (y == 0) res.dz = 1'b1;
        else begin res.lo = x / y; res.hi = x % y; end
      end
    endcase
    return res;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
      end
    end else if (rst && div_by_zero) begin
      checks++;
      errors++;
      $display("FAIL stray_dz: got div_by_zero=1 expected 0 without done");
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, y,
                       input bit glitch, input bit with_lo_we);
    exp_t        e;
    logic [31:0] old_lo;
    int          cnt;
    op = o; a = x; b = y; start = 1'b1;
    lo_we = with_lo_we; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    old_lo = model_lo;
    e = ref_model(o, x, y, model_hi, model_lo);
    sb.push_back(e);
    if (!e.dz) begin model_hi = e.hi; model_lo = e.lo; end
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    if (with_lo_we) chk("start_beats_lo_we", {32'd0, lo}, {32'd0, old_lo});
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      start = (glitch && cnt == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", 64'(cnt), 64'd34);
  endtask

  task automatic mt(input bit he, input bit le, input logic [31:0] v);
    hi_we = he; lo_we = le; wdata = v;
    @(posedge clk);
    if (he) model_hi = v;
    if (le) model_lo = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_hi", {32'd0, hi}, {32'd0, model_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, model_lo});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    logic [31:0] x, y;
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    mt(1'b1, 1'b0, 32'h1234_5678);
    chk("mthi_value", {32'd0, hi}, 64'h1234_5678);

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_done", {63'd0, done}, 64'd1);
    chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0001);
    @(negedge clk);

    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    @(negedge clk);

    // DIVU launched in the done cycle of the DIV.
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    issue(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_lo", {32'd0, lo}, 64'd3);
    chk("divu_hi", {32'd0, hi}, 64'd1);
    @(negedge clk);

    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_wrap_lo", {32'd0, lo}, 64'h8000_0000);
    chk("div_wrap_hi", {32'd0, hi}, 64'd0);
    @(negedge clk);

    mt(1'b1, 1'b0, 32'hAAAA_0000);
    mt(1'b0, 1'b1, 32'h0000_5555);
    issue(2'd3, 32'd123, 32'd0, 1'b0, 1'b0);
    chk("dz_flag", {63'd0, div_by_zero}, 64'd1);
    chk("dz_hi_kept", {32'd0, hi}, 64'hAAAA_0000);
    chk("dz_lo_kept", {32'd0, lo}, 64'h0000_5555);
    @(negedge clk);

    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    issue(2'd1, 32'd3, 32'd5, 1'b0, 1'b1);
    chk("lo_we_op_lo", {32'd0, lo}, 64'd15);
    @(negedge clk);

    issue(2'd0, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_relaunch_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a MULT.
    op = 2'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_hi = '0; model_lo = '0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(dcount), 64'd0);

    for (int n = 0; n < 30; n++) begin
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = -$urandom_range(1, 15);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, 1'b1, $urandom);
      issue(2'($urandom_range(0, 3)), x, y, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
